cache_access_gen: RTL and testbench

- Upstream stimulus stage for the cache systems (direct, 2-way, 4-way); replaces hand-written random-address loops in benches and the FPGA demo top.
- Issues a programmed number of single-cycle read requests with an 11-bit address in a selectable pattern, then waits for each response.
- Tallies L1 hits, L2 hits and misses from the responses and reports completion.

---
 rtl/cache_gen_pkg.sv | 23 ++
 rtl/cache_lfsr16.sv | 23 ++
 rtl/cache_access_gen.sv | 189 ++++++++++++++++++
 tb/tb_cache_access_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_gen_pkg.sv
// Shared encodings and the LFSR step function for the cache access generator.
package cache_gen_pkg;

    localparam logic [1:0] MODE_SEQ    = 2'd0;
    localparam logic [1:0] MODE_STRIDE = 2'd1;
    localparam logic [1:0] MODE_RANDOM = 2'd2;
    localparam logic [1:0] MODE_LOOP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/cache_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance enable; a zero seed loads the default.
module cache_lfsr16
    import cache_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            state <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/cache_access_gen.sv
// Cache access generator: issues a programmed run of reads and tallies L1/L2 hits and misses.
// Define ACCESS_GEN_TIMEOUT_EN to bound each response wait and add the sticky timeout_err output.
module cache_access_gen
    import cache_gen_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int CNT_W          = 16,
    parameter int LOOP_LEN       = 64,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_accesses,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [15:0]       seed,
    input  logic              resp_valid,
    input  logic              l1_hit,
    input  logic              l2_hit,
    output logic [ADDR_W-1:0] addr,
    output logic              read,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  access_idx,
    output logic [CNT_W-1:0]  l1_hits,
    output logic [CNT_W-1:0]  l2_hits,
    output logic [CNT_W-1:0]  misses
`ifdef ACCESS_GEN_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam logic [ADDR_W-1:0] LOOP_MASK = ADDR_W'(LOOP_LEN - 1);

    gen_state_t        state;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  num_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rand_next;
    logic [CNT_W-1:0]  next_idx;
    logic [15:0]       seed_eff;
    logic [15:0]       lfsr_state;
    logic              start_run;
    logic              take;
    logic              timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign start_run  = (state == ST_IDLE) && start;
    assign seed_eff   = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    assign first_addr = (mode == MODE_RANDOM) ? seed_eff[ADDR_W-1:0] : base_addr;
    assign take       = (state == ST_WAIT) && (resp_valid || timeout_hit);
    assign next_idx   = access_idx + CNT_W'(1);
    assign rand_next  = ADDR_W'(lfsr_step(lfsr_state));

    cache_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_run),
        .seed    (seed_eff),
        .advance (take),
        .state   (lfsr_state)
    );

    // The RANDOM address uses the post-advance LFSR value so it lines up with the register update.
    always_comb begin
        next_addr = addr;
        case (mode_q)
            MODE_SEQ:    next_addr = addr + ADDR_W'(1);
            MODE_STRIDE: next_addr = addr + stride_q;
            MODE_RANDOM: next_addr = rand_next;
            MODE_LOOP:   next_addr = base_q + (ADDR_W'(next_idx) & LOOP_MASK);
            default:     next_addr = addr;
        endcase
    end

`ifdef ACCESS_GEN_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign timeout_hit = (state == ST_WAIT) && !resp_valid &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state != ST_WAIT) || take) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (start_run) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_SEQ;
            num_q      <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            addr       <= '0;
            read       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            access_idx <= '0;
            l1_hits    <= '0;
            l2_hits    <= '0;
            misses     <= '0;
        end else begin
            read <= 1'b0;
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        num_q      <= num_accesses;
                        base_q     <= base_addr;
                        stride_q   <= stride;
                        addr       <= first_addr;
                        access_idx <= '0;
                        l1_hits    <= '0;
                        l2_hits    <= '0;
                        misses     <= '0;
                        if (num_accesses == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_ISSUE;
                            read  <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (take) begin
                        // A timed-out access is always a miss, whatever the flag inputs say.
                        if (timeout_hit || (!l1_hit && !l2_hit)) begin
                            misses <= sat_inc(misses);
                        end else if (l1_hit) begin
                            l1_hits <= sat_inc(l1_hits);
                        end else begin
                            l2_hits <= sat_inc(l2_hits);
                        end
                        access_idx <= next_idx;
                        if (next_idx == num_q) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                        end else begin
                            addr  <= next_addr;
                            state <= ST_ISSUE;
                            read  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_access_gen.sv
// Scoreboard bench for cache_access_gen: expected addresses and end-of-run tallies are queued
// when a run is started and popped by a monitor whenever read or done is presented.
module tb_cache_access_gen;
    import cache_gen_pkg::*;

    typedef struct {
        logic [15:0] idx;
        logic [15:0] l1;
        logic [15:0] l2;
        logic [15:0] miss;
    } done_rec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] num_accesses;
    logic [10:0] base_addr;
    logic [10:0] stride;
    logic [15:0] seed;
    logic        resp_valid;
    logic        l1_hit;
    logic        l2_hit;
    logic [10:0] addr;
    logic        read;
    logic        busy;
    logic        done;
    logic [15:0] access_idx;
    logic [15:0] l1_hits;
    logic [15:0] l2_hits;
    logic [15:0] misses;
`ifdef ACCESS_GEN_TIMEOUT_EN
    logic        timeout_err;
`endif

    logic [10:0] exp_addr_q[$];
    done_rec_t   exp_done_q[$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          done_count  = 0;
    int          read_count  = 0;

    cache_access_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .num_accesses (num_accesses),
        .base_addr    (base_addr),
        .stride       (stride),
        .seed         (seed),
        .resp_valid   (resp_valid),
        .l1_hit       (l1_hit),
        .l2_hit       (l2_hit),
        .addr         (addr),
        .read         (read),
        .busy         (busy),
        .done         (done),
        .access_idx   (access_idx),
        .l1_hits      (l1_hits),
        .l2_hits      (l2_hits),
        .misses       (misses)
`ifdef ACCESS_GEN_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic boundFail(input string name);
        check_count++;
        $display("[TB] FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    // Monitor: every read pops an expected address, every done pops an expected tally.
    always @(negedge clk) begin
        if (rst) begin
            if (read) begin
                read_count++;
                if (exp_addr_q.size() == 0) begin
                    boundFail("addr_unexpected_read");
                end else begin
                    checkOutput("addr", 32'(addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (done) begin
                done_rec_t rec;
                done_count++;
                if (exp_done_q.size() == 0) begin
                    boundFail("done_unexpected");
                end else begin
                    rec = exp_done_q.pop_front();
                    checkOutput("done_access_idx", 32'(access_idx), 32'(rec.idx));
                    checkOutput("done_l1_hits",    32'(l1_hits),    32'(rec.l1));
                    checkOutput("done_l2_hits",    32'(l2_hits),    32'(rec.l2));
                    checkOutput("done_misses",     32'(misses),     32'(rec.miss));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] n, input logic [10:0] b,
                                 input logic [10:0] s, input logic [15:0] sd);
        @(posedge clk);
        #1;
        mode         = m;
        num_accesses = n;
        base_addr    = b;
        stride       = s;
        seed         = sd;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // pat 0: all miss; 1: l1 on even (with l2 also set), l2 on odd; 2: all l2; 3: l1/l2/miss by k%3
    task automatic respFlags(input int pat, input int k, output logic f1, output logic f2);
        case (pat)
            1:       begin f1 = (k % 2 == 0); f2 = 1'b1; end
            2:       begin f1 = 1'b0; f2 = 1'b1; end
            3:       begin f1 = (k % 3 == 0); f2 = (k % 3 == 1); end
            default: begin f1 = 1'b0; f2 = 1'b0; end
        endcase
    endtask

    task automatic serve(input int n, input int pat, input int dly, input int inject_at, input bit spurious);
        int   budget;
        logic f1;
        logic f2;
        for (int k = 0; k < n; k++) begin
            budget = 0;
            @(negedge clk);
            while (read !== 1'b1 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (read !== 1'b1) begin
                boundFail("read_wait");
                return;
            end
            if (spurious) begin
                resp_valid = 1'b1;
                l1_hit     = 1'b1;
                l2_hit     = 1'b0;
            end
            for (int j = 0; j < dly; j++) begin
                @(posedge clk);
                #1;
                resp_valid = 1'b0;
                start      = (k == inject_at) && (j == 0);
                if (start) begin
                    mode         = MODE_SEQ;
                    num_accesses = 16'd1;
                    base_addr    = 11'h555;
                end
            end
            start = 1'b0;
            respFlags(pat, k, f1, f2);
            resp_valid = 1'b1;
            l1_hit     = f1;
            l2_hit     = f2;
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
            l1_hit     = 1'b0;
            l2_hit     = 1'b0;
        end
    endtask

    task automatic waitDone(input int target, input int budget);
        int cyc;
        cyc = 0;
        @(negedge clk);
        #1;
        while (done_count < target && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("done_count", 32'(done_count), 32'(target));
    endtask

    task automatic pushRec(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
        done_rec_t r;
        r.idx = i; r.l1 = a; r.l2 = b; r.miss = c;
        exp_done_q.push_back(r);
    endtask

    initial begin
        int dc;
        int rc;
        rst = 1'b0; start = 1'b0; mode = 2'd0; num_accesses = '0; base_addr = '0;
        stride = '0; seed = '0; resp_valid = 1'b0; l1_hit = 1'b0; l2_hit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_addr", 32'(addr), 32'h0);
        checkOutput("reset_read", 32'(read), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_idx",  32'(access_idx), 32'h0);
        checkOutput("reset_cnts", 32'({l1_hits, l2_hits} | 32'(misses)), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // SEQ wrapping past the top of the address space
        exp_addr_q = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        pushRec(16'd4, 16'd0, 16'd0, 16'd4);
        applyStimulus(MODE_SEQ, 16'd4, 11'h7FE, 11'h000, 16'h0000);
        serve(4, 0, 2, -1, 1'b0);
        waitDone(1, 20);

        // STRIDE with a start pulse injected mid-run that must be ignored
        exp_addr_q = '{11'h100, 11'h400, 11'h700};
        pushRec(16'd3, 16'd1, 16'd1, 16'd1);
        applyStimulus(MODE_STRIDE, 16'd3, 11'h100, 11'h300, 16'h0000);
        serve(3, 3, 2, 1, 1'b0);
        waitDone(2, 20);
        repeat (6) @(negedge clk);
        checkOutput("stride_single_done", 32'(done_count), 32'd2);
        checkOutput("stride_idle_busy", 32'(busy), 32'd0);

        // RANDOM, zero seed falls back to 0xACE1
        exp_addr_q = '{11'h4E1, 11'h1C3, 11'h387, 11'h70F};
        pushRec(16'd4, 16'd0, 16'd4, 16'd0);
        applyStimulus(MODE_RANDOM, 16'd4, 11'h000, 11'h000, 16'h0000);
        serve(4, 2, 1, -1, 1'b0);
        waitDone(3, 20);

        // RANDOM, explicit 0xACE1; a resp_valid during each ISSUE cycle must be ignored
        exp_addr_q = '{11'h4E1, 11'h1C3, 11'h387, 11'h70F};
        pushRec(16'd4, 16'd2, 16'd2, 16'd0);
        applyStimulus(MODE_RANDOM, 16'd4, 11'h000, 11'h000, 16'hACE1);
        serve(4, 1, 2, -1, 1'b1);
        waitDone(4, 20);

        // LOOP of 70 accesses over a 64-entry working set
        exp_addr_q.delete();
        for (int i = 0; i < 70; i++) exp_addr_q.push_back(11'h010 + 11'(i % 64));
        pushRec(16'd70, 16'd35, 16'd35, 16'd0);
        applyStimulus(MODE_LOOP, 16'd70, 11'h010, 11'h000, 16'h0000);
        serve(70, 1, 1, -1, 1'b0);
        waitDone(5, 20);

        // Zero-length run: done two cycles after start, no read
        rc = read_count;
        pushRec(16'd0, 16'd0, 16'd0, 16'd0);
        applyStimulus(MODE_SEQ, 16'd0, 11'h222, 11'h000, 16'h0000);
        @(negedge clk);
        checkOutput("zero_done_early", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("zero_done_2cyc", 32'(done), 32'd1);
        waitDone(6, 10);
        checkOutput("zero_no_read", 32'(read_count), 32'(rc));

        // Asynchronous abort in WAIT
        exp_addr_q = '{11'h123};
        applyStimulus(MODE_SEQ, 16'd8, 11'h123, 11'h000, 16'h0000);
        @(negedge clk);
        @(posedge clk);
        #3;
        dc = done_count;
        rst = 1'b0;
        #1;
        checkOutput("abort_addr", 32'(addr), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_read", 32'(read), 32'h0);
        checkOutput("abort_idx",  32'(access_idx), 32'h0);
        exp_addr_q.delete();
        repeat (5) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_count), 32'(dc));
        checkOutput("abort_done_low", 32'(done), 32'h0);
        rst = 1'b1;

`ifdef ACCESS_GEN_TIMEOUT_EN
        exp_addr_q = '{11'h0AA};
        pushRec(16'd1, 16'd0, 16'd0, 16'd1);
        applyStimulus(MODE_SEQ, 16'd1, 11'h0AA, 11'h000, 16'h0000);
        checkOutput("timeout_err_clear", 32'(timeout_err), 32'd0);
        waitDone(7, 60);
        checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        checkOutput("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
